// File: rtl/regfile_wb_unit.sv
// regfile_wb_unit: write-back collector for the single regfile write port.
// Merges single-cycle ALU results with variable-latency loads held in an
// in-order queue, and drives a registered write port to the register file.
// Also provides a pending-load scoreboard so decode can stall.
// Optional feature macro: REGFILE_WB_BYPASS_EN. When it is defined, a load
// that arrives at an empty queue with no competing ALU write goes straight
// to the output register.
module regfile_wb_unit #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ADDR_W-1:0]          ld_rd,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       wsig,
    output logic [ADDR_W-1:0]          wadd,
    output logic [DATA_W-1:0]          wdata,
    input  logic [ADDR_W-1:0]          pend_q1,
    input  logic [ADDR_W-1:0]          pend_q2,
    output logic                       pend_hit1,
    output logic                       pend_hit2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Queue storage; q_vld doubles as the kill mask for queued entries.
    logic [ADDR_W-1:0] q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Output stage holds a load write (from queue or bypass) rather than ALU.
    logic out_ld;

    logic q_empty;
    logic alu_win;
    logic ld_accept;
    logic ld_live;
    logic pop;
    logic push;
    logic bypass;
    logic hit1;
    logic hit2;

    // Handshake depends only on registered occupancy, never on a same-cycle pop.
    assign ld_ready = rst && (count < CW'(DEPTH));

    // Arbitration and queue control decisions for this cycle.
    always_comb begin
        q_empty   = (count == '0);
        alu_win   = alu_valid && (alu_rd != '0);
        ld_accept = ld_valid && ld_ready;
        // A same-cycle load to the ALU's rd is older and therefore dead on arrival.
        ld_live   = ld_accept && (ld_rd != '0) && !(alu_win && (ld_rd == alu_rd));
        pop       = !alu_win && !q_empty;
`ifdef REGFILE_WB_BYPASS_EN
        bypass    = ld_live && q_empty && !alu_win;
`else
        bypass    = 1'b0;
`endif
        push      = ld_live && !bypass;
    end

    // Queue pointers, occupancy and valid/kill bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else begin
            // Kill first; pop and push below never target a slot being killed
            // in a way that conflicts, since pop is suppressed when the ALU wins.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alu_win && (q_rd[PW'(i)] == alu_rd)) begin
                    q_vld[PW'(i)] <= 1'b0;
                end
            end
            if (pop) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue payload storage; contents are meaningful only under q_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= ld_rd;
            q_data[wr_ptr] <= ld_data;
        end
    end

    // Registered write port: ALU first, then queue head, then bypassed load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wsig   <= 1'b0;
            wadd   <= '0;
            wdata  <= '0;
            out_ld <= 1'b0;
        end else if (alu_win) begin
            wsig   <= 1'b1;
            wadd   <= alu_rd;
            wdata  <= alu_data;
            out_ld <= 1'b0;
        end else if (pop) begin
            // A killed head is still popped but produces no write.
            wsig   <= q_vld[rd_ptr];
            out_ld <= q_vld[rd_ptr];
            if (q_vld[rd_ptr]) begin
                wadd  <= q_rd[rd_ptr];
                wdata <= q_data[rd_ptr];
            end
        end else if (bypass) begin
            wsig   <= 1'b1;
            wadd   <= ld_rd;
            wdata  <= ld_data;
            out_ld <= 1'b1;
        end else begin
            wsig   <= 1'b0;
            out_ld <= 1'b0;
        end
    end

    // Scoreboard lookup over live queue entries plus a staged load write.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_vld[PW'(i)] && (q_rd[PW'(i)] == pend_q1)) hit1 = 1'b1;
            if (q_vld[PW'(i)] && (q_rd[PW'(i)] == pend_q2)) hit2 = 1'b1;
        end
        if (wsig && out_ld && (wadd == pend_q1)) hit1 = 1'b1;
        if (wsig && out_ld && (wadd == pend_q2)) hit2 = 1'b1;
        pend_hit1 = rst && (pend_q1 != '0) && hit1;
        pend_hit2 = rst && (pend_q2 != '0) && hit2;
    end

    // Structural invariants of the queue and write port.
    a_count_bound : assert property (@(posedge clk) disable iff (!rst)
        count <= CW'(DEPTH));
    a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
        push |-> (count < CW'(DEPTH)));
    a_no_r0_write : assert property (@(posedge clk) disable iff (!rst)
        wsig |-> (wadd != '0));

endmodule

// File: tb/tb_regfile_wb_unit.sv
// Directed testbench for regfile_wb_unit (DEPTH=4, DATA_W=32, ADDR_W=5).
// Bypass expectations follow REGFILE_WB_BYPASS_EN as defined for the build.
module tb_regfile_wb_unit;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              wsig;
    logic [ADDR_W-1:0] wadd;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] pend_q1;
    logic [ADDR_W-1:0] pend_q2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic [CW-1:0]     count;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_wb_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .wsig      (wsig),
        .wadd      (wadd),
        .wdata     (wdata),
        .pend_q1   (pend_q1),
        .pend_q2   (pend_q2),
        .pend_hit1 (pend_hit1),
        .pend_hit2 (pend_hit2),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic set_ld(input logic v, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
        ld_valid = v;
        ld_rd    = rd;
        ld_data  = d;
    endtask

    initial begin
        rst     = 1'b0;
        pend_q1 = 5'd3;
        pend_q2 = 5'd0;
        set_alu(1'b1, 5'd5, 32'h5555_5555);
        set_ld(1'b1, 5'd3, 32'h3333_3333);

        // Reset held for two edges with traffic present.
        tick;
        tick;
        check("rst_wsig",  64'(wsig),      64'd0);
        check("rst_wadd",  64'(wadd),      64'd0);
        check("rst_wdata", 64'(wdata),     64'd0);
        check("rst_count", 64'(count),     64'd0);
        check("rst_ready", 64'(ld_ready),  64'd0);
        check("rst_hit1",  64'(pend_hit1), 64'd0);
        rst = 1'b1;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        #1;
        check("rel_ready", 64'(ld_ready), 64'd1);
        tick;
        check("rel_wsig",  64'(wsig),  64'd0);
        check("rel_count", 64'(count), 64'd0);

        // ALU only.
        set_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick;
        check("alu_wsig",  64'(wsig),  64'd1);
        check("alu_wadd",  64'(wadd),  64'd5);
        check("alu_wdata", 64'(wdata), 64'hDEAD_BEEF);
        set_alu(1'b1, 5'd0, 32'h1234);
        tick;
        check("alu_r0_wsig", 64'(wsig), 64'd0);
        set_alu(1'b0, 5'd0, 32'h0);
        tick;

        // Fill the queue while the ALU starves it.
        for (int i = 1; i <= DEPTH; i++) begin
            set_alu(1'b1, 5'd20, 32'(32'hA0 + i));
            set_ld(1'b1, 5'(i), 32'(32'h100 + i));
            tick;
            check("fill_wadd",  64'(wadd),  64'd20);
            check("fill_wdata", 64'(wdata), 64'(32'hA0 + i));
        end
        check("full_count", 64'(count),     64'd4);
        check("full_ready", 64'(ld_ready),  64'd0);
        check("full_hit1",  64'(pend_hit1), 64'd1);
        check("full_hit2",  64'(pend_hit2), 64'd0);
        set_ld(1'b1, 5'd5, 32'h555);
        tick;
        check("full_hold_count", 64'(count), 64'd4);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        for (int i = 1; i <= DEPTH; i++) begin
            tick;
            check("drain_wsig",  64'(wsig),  64'd1);
            check("drain_wadd",  64'(wadd),  64'(i));
            check("drain_wdata", 64'(wdata), 64'(32'h100 + i));
            check("drain_count", 64'(count), 64'(DEPTH - i));
        end
        check("drain_ready", 64'(ld_ready), 64'd1);
        tick;
        check("drain_idle", 64'(wsig), 64'd0);

        // Kill ordering: queued load to r7 then ALU to r7.
        pend_q1 = 5'd7;
        set_alu(1'b1, 5'd20, 32'h20);
        set_ld(1'b1, 5'd7, 32'h11);
        tick;
        check("kill_q_count", 64'(count),     64'd1);
        check("kill_q_hit1",  64'(pend_hit1), 64'd1);
        set_alu(1'b1, 5'd7, 32'h22);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("kill_wsig",  64'(wsig),      64'd1);
        check("kill_wadd",  64'(wadd),      64'd7);
        check("kill_wdata", 64'(wdata),     64'h22);
        check("kill_count", 64'(count),     64'd1);
        check("kill_hit1",  64'(pend_hit1), 64'd0);
        set_alu(1'b0, 5'd0, 32'h0);
        tick;
        check("kill_pop_wsig",  64'(wsig),  64'd0);
        check("kill_pop_count", 64'(count), 64'd0);
        tick;
        check("kill_after_wsig", 64'(wsig), 64'd0);

        // Same-cycle load and ALU to the same rd.
        set_alu(1'b1, 5'd8, 32'h88);
        set_ld(1'b1, 5'd8, 32'h80);
        #1;
        check("same_ready", 64'(ld_ready), 64'd1);
        tick;
        check("same_wadd",  64'(wadd),  64'd8);
        check("same_wdata", 64'(wdata), 64'h88);
        check("same_count", 64'(count), 64'd0);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("same_after_wsig", 64'(wsig), 64'd0);

        // Load to r0 is accepted but dropped.
        set_ld(1'b1, 5'd0, 32'hFF);
        tick;
        check("ld_r0_count", 64'(count), 64'd0);
        check("ld_r0_wsig",  64'(wsig),  64'd0);
        set_ld(1'b0, 5'd0, 32'h0);

        // Scoreboard across queue and staged write.
        pend_q1 = 5'd9;
        pend_q2 = 5'd0;
        set_alu(1'b1, 5'd20, 32'h21);
        set_ld(1'b1, 5'd9, 32'h99);
        tick;
        check("sb_hit1_q",  64'(pend_hit1), 64'd1);
        check("sb_hit2_r0", 64'(pend_hit2), 64'd0);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("sb_hit1_wait", 64'(pend_hit1), 64'd1);
        set_alu(1'b0, 5'd0, 32'h0);
        tick;
        check("sb_wadd",       64'(wadd),      64'd9);
        check("sb_wdata",      64'(wdata),     64'h99);
        check("sb_hit1_stage", 64'(pend_hit1), 64'd1);
        tick;
        check("sb_idle_wsig", 64'(wsig),      64'd0);
        check("sb_hit1_done", 64'(pend_hit1), 64'd0);

        // Simultaneous push and pop keeps the count.
        set_alu(1'b1, 5'd20, 32'h22);
        set_ld(1'b1, 5'd11, 32'hB1);
        tick;
        check("pp_count1", 64'(count), 64'd1);
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b1, 5'd12, 32'hC2);
        tick;
        check("pp_wadd1",  64'(wadd),  64'd11);
        check("pp_count2", 64'(count), 64'd1);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("pp_wadd2",  64'(wadd),  64'd12);
        check("pp_wdata2", 64'(wdata), 64'hC2);
        check("pp_count3", 64'(count), 64'd0);
        tick;
        check("pp_idle", 64'(wsig), 64'd0);

        // Load into an empty queue with the ALU idle.
        pend_q1 = 5'd3;
        set_ld(1'b1, 5'd3, 32'h33);
        tick;
`ifdef REGFILE_WB_BYPASS_EN
        check("byp_wsig",  64'(wsig),      64'd1);
        check("byp_wadd",  64'(wadd),      64'd3);
        check("byp_wdata", 64'(wdata),     64'h33);
        check("byp_count", 64'(count),     64'd0);
        check("byp_hit1",  64'(pend_hit1), 64'd1);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("byp_idle", 64'(wsig), 64'd0);
`else
        check("nobyp_wsig0", 64'(wsig),      64'd0);
        check("nobyp_count", 64'(count),     64'd1);
        check("nobyp_hit1",  64'(pend_hit1), 64'd1);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("nobyp_wsig",  64'(wsig),  64'd1);
        check("nobyp_wadd",  64'(wadd),  64'd3);
        check("nobyp_wdata", 64'(wdata), 64'h33);
        check("nobyp_cnt0",  64'(count), 64'd0);
        tick;
        check("nobyp_idle", 64'(wsig), 64'd0);
`endif

        // Reset mid-operation discards queued loads.
        set_alu(1'b1, 5'd20, 32'h23);
        set_ld(1'b1, 5'd13, 32'hD1);
        tick;
        set_ld(1'b1, 5'd14, 32'hE1);
        tick;
        check("mid_count", 64'(count), 64'd2);
        rst = 1'b0;
        set_alu(1'b0, 5'd0, 32'h0);
        set_ld(1'b0, 5'd0, 32'h0);
        tick;
        check("mid_rst_count", 64'(count),    64'd0);
        check("mid_rst_wsig",  64'(wsig),     64'd0);
        check("mid_rst_ready", 64'(ld_ready), 64'd0);
        rst = 1'b1;
        tick;
        check("mid_rel_wsig1", 64'(wsig), 64'd0);
        tick;
        check("mid_rel_wsig2", 64'(wsig),  64'd0);
        check("mid_rel_count", 64'(count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
